// File: rtl/led_pattern_arbiter.sv
// led_pattern_arbiter: round-robin owner of the user LED; plays the owner's 32-bit pattern LSB-first,
// then a dark gap, then pulses done.
module led_pattern_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TICK_DIV  = 2097152,
  parameter int REPEATS   = 1,
  parameter int GAP_TICKS = 4
) (
  input  logic                 clk_16mhz,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  pattern,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic                 user_led
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_REQ);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [3:0] REP_LAST = 4'(REPEATS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t        state;
  logic [IW-1:0] last_grant, next_idx, cand;
  logic          found;
  logic [31:0]   pat_reg;
  logic [TW-1:0] tick_cnt;
  logic [4:0]    bit_idx;
  logic [3:0]    rep_cnt, gap_cnt;
  logic          tick_wrap;

  assign tick_wrap = tick_cnt == TICK_MAX;
  assign user_led  = (state == PLAY) && pat_reg[bit_idx];

  // search upward from the requester after the previous owner, wrapping
  always_comb begin
    next_idx = last_grant;
    found = 1'b0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        next_idx = cand;
      end
    end
  end

  // last_grant is the current owner while busy, so an abort keeps fairness
  always_ff @(posedge clk_16mhz) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      last_grant <= IW'(N_REQ - 1);
      pat_reg    <= '0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= '0;
      if (state == IDLE) begin
        if (found) begin
          grant      <= N_REQ'(1) << next_idx;
          last_grant <= next_idx;
          busy       <= 1'b1;
          state      <= LOAD;
        end
      end else if (!req[last_grant]) begin
        state <= IDLE;
        grant <= '0;
        busy  <= 1'b0;
      end else if (state == LOAD) begin
        pat_reg  <= pattern[{last_grant, 5'b0} +: 32];
        tick_cnt <= '0;
        bit_idx  <= '0;
        rep_cnt  <= '0;
        state    <= PLAY;
      end else begin
        tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
        if (tick_wrap && state == PLAY) begin
          bit_idx <= bit_idx + 5'd1;
          if (bit_idx == 5'd31) begin
            rep_cnt <= rep_cnt + 4'd1;
            if (rep_cnt == REP_LAST) begin
              gap_cnt <= '0;
              if (GAP_TICKS == 0) begin
                done  <= grant;
                grant <= '0;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= GAP;
              end
            end
          end
        end else if (tick_wrap && state == GAP) begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == GAP_LAST) begin
            done  <= grant;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule
